// File: rtl/dut.sv
// Sequential signed 8x8 multiplier with a private 256-byte data memory.
// Operand A is read from byte 0 and operand B from byte 1. The 16-bit
// two's-complement product is written little-endian to bytes 2 and 3,
// and then done is raised.
//
// Ports (dut):
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high; returns the controller to IDLE
//   start - a high-to-low transition starts one multiply
//   done  - high from the end of an operation until start returns high
//
// Ports (dmem):
//   clk, we, addr[7:0], wdata[7:0] - synchronous write port
//   rdata[7:0]                     - combinational read of core[addr]

module dmem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  // The memory has no reset, so its contents survive a controller reset.
  logic [7:0] core [0:255];

  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end

  assign rdata = core[addr];
endmodule

// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for a falling edge on start
// S_LOAD_A   | latch operand A from byte 0
// S_LOAD_B   | latch operand B from byte 1, set up magnitudes and sign
// S_MUL      | one shift-add iteration per cycle, 8 iterations in total
// S_STORE_LO | write product[7:0] to byte 2
// S_STORE_HI | write product[15:8] to byte 3
// S_DONE     | done asserted; leave this state once start is high again
module dut (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_MUL, S_STORE_LO, S_STORE_HI, S_DONE
  } state_t;

  state_t      state, state_nx;
  logic        start_q;
  logic        trigger;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  a_q;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [15:0] acc;
  logic [15:0] acc_sum;
  logic [2:0]  cnt;
  logic        neg;

  dmem dm (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // The magnitude is returned as unsigned 8-bit, so |-128| comes out as 0x80 (128).
  function automatic logic [7:0] mag(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction

  // start_q resets high, so if start is already low at the first edge
  // after reset is released, that edge counts as a trigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) start_q <= 1'b1;
    else       start_q <= start;
  end

  assign trigger = start_q & ~start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_we    = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    case (state)
      S_IDLE:     if (trigger) state_nx = S_LOAD_A;
      S_LOAD_A: begin
        mem_addr = 8'd0;
        state_nx = S_LOAD_B;
      end
      S_LOAD_B: begin
        mem_addr = 8'd1;
        state_nx = S_MUL;
      end
      S_MUL:      if (cnt == 3'd7) state_nx = S_STORE_LO;
      S_STORE_LO: begin
        mem_we    = 1'b1;
        mem_addr  = 8'd2;
        mem_wdata = acc[7:0];
        state_nx  = S_STORE_HI;
      end
      S_STORE_HI: begin
        mem_we    = 1'b1;
        mem_addr  = 8'd3;
        mem_wdata = acc[15:8];
        state_nx  = S_DONE;
      end
      S_DONE:     if (start) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  assign acc_sum = acc + (mplier[0] ? mcand : 16'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= 8'd0;
      mcand  <= 16'd0;
      mplier <= 8'd0;
      acc    <= 16'd0;
      cnt    <= 3'd0;
      neg    <= 1'b0;
    end else begin
      case (state)
        S_LOAD_A: a_q <= mem_rdata;
        S_LOAD_B: begin
          mcand  <= {8'd0, mag(a_q)};
          mplier <= mag(mem_rdata);
          neg    <= a_q[7] ^ mem_rdata[7];
          acc    <= 16'd0;
          cnt    <= 3'd0;
        end
        S_MUL: begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          // The sign is applied on the last iteration. Negating a zero
          // product still gives 0.
          if (cnt == 3'd7) acc <= neg ? (-acc_sum) : acc_sum;
          else             acc <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  // done rises one edge after the controller enters S_DONE. It falls on
  // the edge where start is sampled high, which is also the edge that
  // returns the controller to S_IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (state == S_DONE) && !start;
  end
endmodule

// File: tb/tb_dut.sv
// Self-checking bench for dut. The expected products are computed with
// plain signed integer arithmetic. A shadow copy of the whole memory is
// kept so the bench can detect any write outside bytes 2 and 3.
//
// Ports: none (top-level bench).
module tb_dut;
  logic clk;
  logic reset;
  logic start;
  logic done;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] mem_ref [0:255];

  dut u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count positive edges from the trigger edge until done is seen high.
  // The trigger edge itself is not counted.
  task automatic wait_done(output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) begin
        lat = n - 1;
        break;
      end
    end
  endtask

  function automatic int other_diffs();
    int d;
    d = 0;
    for (int i = 0; i < 256; i++)
      if (i != 2 && i != 3 && u_dut.dm.core[i] !== mem_ref[i]) d++;
    return d;
  endfunction

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    byte sa, sb;
    int  p;
    sa = a;
    sb = b;
    p  = int'(sa) * int'(sb);
    return 16'(p);
  endfunction

  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    u_dut.dm.core[0] = a;
    u_dut.dm.core[1] = b;
    mem_ref[0] = a;
    mem_ref[1] = b;
  endtask

  // One complete run: load the operands, drop start, then check the
  // latency, the result bytes, the untouched bytes and the end of the run.
  task automatic do_run(input string tag, input logic [7:0] a, input logic [7:0] b);
    int lat;
    logic [15:0] p;
    p = ref_prod(a, b);
    @(negedge clk);
    load_ops(a, b);
    start = 1'b0;
    wait_done(lat);
    chk({tag, " latency"}, 32'(lat), 32'd13);
    chk({tag, " lo"}, 32'(u_dut.dm.core[2]), 32'(p[7:0]));
    chk({tag, " hi"}, 32'(u_dut.dm.core[3]), 32'(p[15:8]));
    mem_ref[2] = p[7:0];
    mem_ref[3] = p[15:8];
    chk({tag, " others"}, 32'(other_diffs()), 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    chk({tag, " done clear"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    logic [15:0] p;
    reset = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem_ref[i] = 8'($urandom_range(0, 255));
      u_dut.dm.core[i] = mem_ref[i];
    end
    load_ops(8'd2, 8'hFC);
    repeat (3) @(posedge clk);
    #1;
    chk("reset done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // With start held high there is no trigger, so done must stay low.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle done", 32'(done), 32'd0);
    end

    do_run("2x-4", 8'd2, 8'hFC);
    chk("2x-4 lo const", 32'(u_dut.dm.core[2]), 32'hF8);
    chk("2x-4 hi const", 32'(u_dut.dm.core[3]), 32'hFF);
    do_run("-128x-128", 8'h80, 8'h80);
    chk("-128x-128 hi const", 32'(u_dut.dm.core[3]), 32'h40);
    do_run("127x-128", 8'h7F, 8'h80);
    chk("127x-128 hi const", 32'(u_dut.dm.core[3]), 32'hC0);
    do_run("0x-77", 8'h00, 8'hB3);
    do_run("-1x-1", 8'hFF, 8'hFF);
    do_run("5x7", 8'd5, 8'd7);
    chk("5x7 lo const", 32'(u_dut.dm.core[2]), 32'h23);
    for (int i = 0; i < 10; i++)
      do_run("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    // Reset in the middle of a run: nothing may be written and done must stay low.
    @(negedge clk);
    load_ops(8'd9, 8'hF3);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst done", 32'(done), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("midrst hold", 32'(done), 32'd0);
    end
    chk("midrst lo kept", 32'(u_dut.dm.core[2]), 32'(mem_ref[2]));
    chk("midrst hi kept", 32'(u_dut.dm.core[3]), 32'(mem_ref[3]));
    chk("midrst others", 32'(other_diffs()), 32'd0);

    // start is still low when reset is released, so the first edge is a trigger.
    @(negedge clk);
    reset = 1'b0;
    p = ref_prod(8'd9, 8'hF3);
    wait_done(lat);
    chk("postrst latency", 32'(lat), 32'd13);
    chk("postrst lo", 32'(u_dut.dm.core[2]), 32'(p[7:0]));
    chk("postrst hi", 32'(u_dut.dm.core[3]), 32'(p[15:8]));
    mem_ref[2] = p[7:0];
    mem_ref[3] = p[15:8];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    chk("postrst done clear", 32'(done), 32'd0);
    do_run("after rst", 8'hE9, 8'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dut.md
# dut

Sequential signed 8×8 multiplier with an internal 256-byte data memory, used as the "program 2" top-level block. After a start request it reads operand A from memory byte 0 and operand B from byte 1. It writes the 16-bit two's-complement product little-endian to bytes 2 (low) and 3 (high), then raises `done`. The benches preload operands and read results through the data-memory instance `dm` and its array `core`.

## Interface
- No parameters.
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; returns the controller to IDLE (program counter = 0).
- `start`  input  1  request line; a high-to-low transition starts one multiply.
- `done`  output  1  completion flag; high from operation end until `start` returns high or `reset`.
- Internal data memory instance named `dm`:
  - 256 × 8-bit array named `core`, hierarchically writable and readable by benches.
  - Combinational read, synchronous write.

## Operation
- Operands:
  - A = `dm.core[0]`, B = `dm.core[1]`, both signed 8-bit.
  - Product P = A×B, signed 16-bit; always exact, range −16256..16384.
- Results:
  - `dm.core[2]` = P[7:0], `dm.core[3]` = P[15:8].
  - No other memory location is written.
- Memory contents are not affected by `reset`. Benches load operands while `reset` is high.
- Arithmetic:
  - Magnitudes |A|, |B| taken as 8-bit unsigned (|−128| = 128).
  - Unsigned shift-add over 8 iterations into a 16-bit accumulator.
  - Result negated (two's complement) when A[7] XOR B[7] = 1.
  - A zero product stays 0 (no −0 issue).
- Start detection:
  - Register `start_q` samples `start` each clock; reset value 1.
  - Trigger = `start_q`==1 && `start`==0, recognised only in IDLE.
- FSM states: IDLE, LOAD_A, LOAD_B, MUL, STORE_LO, STORE_HI, DONE.
  - IDLE → LOAD_A on trigger.
  - LOAD_A: latch A. → LOAD_B.
  - LOAD_B: latch B, clear accumulator, iteration counter = 0. → MUL.
  - MUL: one iteration per cycle; if multiplier LSB set, add shifted multiplicand; shift. After 8 iterations, apply sign correction. → STORE_LO.
  - STORE_LO: write low byte to address 2. → STORE_HI.
  - STORE_HI: write high byte to address 3. → DONE.
  - DONE: `done`=1. → IDLE when `start`==1; otherwise stay in DONE.
- `start` changes outside IDLE/DONE are ignored; a started operation always completes unless reset.
- Reset mid-operation:
  - FSM returns to IDLE, `done`=0, `start_q`=1, datapath registers cleared.
  - Any byte already written to memory stays; no further writes occur.

## Timing
- Reset values: `done`=0, state IDLE, `start_q`=1, accumulator/operand registers 0.
- `done` is registered; it never asserts before a trigger. No spurious `done` after reset release.
- Latency:
  - Trigger edge = cycle 0. LOAD_A at cycle 1, LOAD_B at 2, MUL at 3–10, STORE_LO at 11, STORE_HI at 12.
  - `done` rises after the cycle-13 edge, i.e. 13 clocks after the trigger edge.
- Result bytes are stable in memory before `done` rises.
- Ending a run:
  - `done` falls on the first rising edge where `start`==1 is sampled in DONE.
  - A later falling edge of `start` starts a new run.
- If `start` is already low at the first edge after `reset` deasserts, that counts as a trigger (because `start_q` resets to 1).

## Test plan
- A=2, B=−4; release reset, drop start → `done` after 13 clocks; core[2]=0xF8, core[3]=0xFF (−8).
- A=−128, B=−128 → core[2]=0x00, core[3]=0x40 (16384); A=127, B=−128 → core[2]=0x80, core[3]=0xC0 (−16256).
- A=0, B=−77 and A=−1, B=−1 → results 0x0000 and 0x0001 respectively; core[0], core[1] and core[4..255] unchanged.
- Hold start high 20 cycles after reset → `done` stays 0. Drop start → `done` exactly 13 clocks later. Raise start → `done` 0 next edge. Drop again with new operands (5×7) → 0x0023.
- Assert reset at cycle 6 of a run → `done`=0 immediately and stays 0. Core[2]/core[3] hold their pre-run values. A fresh start after reset gives the correct product.
